// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: op encodings and FSM states.
package div_unit_pkg;

   // op = {is_mod, is_unsigned}
   localparam logic [1:0] DIV_W  = 2'b00;
   localparam logic [1:0] DIV_WU = 2'b01;
   localparam logic [1:0] MOD_W  = 2'b10;
   localparam logic [1:0] MOD_WU = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_t;

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_mod(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract
// the divisor when it fits and record the quotient bit.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] r_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   r_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           fits;

   always_comb begin
      shifted = {r_in, q_in[WIDTH-1]};
      diff    = shifted - {1'b0, divisor};
      fits    = (shifted >= {1'b0, divisor});
      r_out   = fits ? diff : shifted;
      q_out   = {q_in[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned 32-bit divider for the EX stage; busy stalls the
// pipeline, done pulses for one cycle with the registered result on y.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   div_state_t       state_reg, state_next;
   logic [CW-1:0]    count_reg;
   logic [WIDTH:0]   r_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] divisor_reg;
   logic [WIDTH-1:0] a_orig_reg;
   logic             is_mod_reg;
   logic             q_neg_reg;
   logic             r_neg_reg;
   logic             div_zero_reg;
   logic [WIDTH-1:0] y_reg;
   logic             done_reg;

   logic [WIDTH:0]   r_step;
   logic [WIDTH-1:0] q_step;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic [WIDTH-1:0] result;
   logic             is_signed;
   logic             unused_r_msb;

   // Remainder after every step is below the divisor, so its MSB is always 0.
   assign unused_r_msb = r_reg[WIDTH];
   assign is_signed    = op_is_signed(op);

   div_step #(.WIDTH(WIDTH)) u_step (
      .r_in    (r_reg[WIDTH-1:0]),
      .q_in    (q_reg),
      .divisor (divisor_reg),
      .r_out   (r_step),
      .q_out   (q_step)
   );

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (count_reg == '0) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg != IDLE);
      done = done_reg;
      y    = y_reg;
   end

   always_comb begin
      q_fix = q_neg_reg ? (~q_reg + 1'b1) : q_reg;
      r_fix = r_neg_reg ? (~r_reg[WIDTH-1:0] + 1'b1) : r_reg[WIDTH-1:0];
      if (div_zero_reg) begin
         result = is_mod_reg ? a_orig_reg : '1;
      end else begin
         result = is_mod_reg ? r_fix : q_fix;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg    <= '0;
         r_reg        <= '0;
         q_reg        <= '0;
         divisor_reg  <= '0;
         a_orig_reg   <= '0;
         is_mod_reg   <= 1'b0;
         q_neg_reg    <= 1'b0;
         r_neg_reg    <= 1'b0;
         div_zero_reg <= 1'b0;
         y_reg        <= '0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (!flush) begin
            case (state_reg)
               IDLE: begin
                  if (start) begin
                     is_mod_reg   <= op_is_mod(op);
                     divisor_reg  <= (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
                     q_reg        <= (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
                     r_reg        <= '0;
                     a_orig_reg   <= a;
                     q_neg_reg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                     r_neg_reg    <= is_signed & a[WIDTH-1];
                     div_zero_reg <= (b == '0);
                     count_reg    <= CNT_LAST;
                  end
               end
               CALC: begin
                  r_reg <= r_step;
                  q_reg <= q_step;
                  if (count_reg != '0) count_reg <= count_reg - CNT_ONE;
               end
               FIX: begin
                  y_reg    <= result;
                  done_reg <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: issued ops push expected results and completion
// cycle; a negedge monitor pops and compares on every done pulse.
module tb_div_unit;
   import div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] y;

   div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .y     (y)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] y;
      int          cyc;
      string       name;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      string       name;
   } vec_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] last_y = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total_cnt++;
      if (act === expv) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, " y"}, y, mon_e.y);
            check({mon_e.name, " latency"}, 32'(cyc), 32'(mon_e.cyc));
            check({mon_e.name, " busy_in_done"}, {31'h0, busy}, 32'h0);
            last_y = mon_e.y;
            $display("txn %s: y=%h cycle=%0d", mon_e.name, y, cyc);
         end
      end
   end

   // Call at a negedge; start is sampled at the following posedge.
   task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] ey, input bit push, input string name);
      exp_t e;
      op = o;
      a = aa;
      b = bb;
      start = 1'b1;
      if (push) begin
         e.y = ey;
         e.cyc = cyc + 34;
         e.name = name;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      op = ~o;
      a = 32'hDEAD_BEEF;
      b = 32'h0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      total_cnt++;
      if (sb.size() == 0) pass_cnt++;
      else $display("FAIL %s drain: got %0d pending results expected 0", name, sb.size());
      sb.delete();
   endtask

   vec_t vecs[$] = '{
      '{DIV_WU, 32'd100,        32'd7,        32'd14,         "divwu_100_7"},
      '{MOD_WU, 32'd100,        32'd7,        32'd2,          "modwu_100_7"},
      '{DIV_W,  32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2,  "divw_m100_7"},
      '{MOD_W,  32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFFE,  "modw_m100_7"},
      '{DIV_W,  32'h8000_0005,  32'h0,        32'hFFFF_FFFF,  "divw_by0"},
      '{DIV_WU, 32'h8000_0005,  32'h0,        32'hFFFF_FFFF,  "divwu_by0"},
      '{MOD_W,  32'h8000_0005,  32'h0,        32'h8000_0005,  "modw_by0"},
      '{MOD_WU, 32'h8000_0005,  32'h0,        32'h8000_0005,  "modwu_by0"},
      '{DIV_W,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "divw_ovf"},
      '{MOD_W,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         "modw_ovf"},
      '{DIV_W,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, "divw_7_m2"},
      '{MOD_W,  32'd7,          32'hFFFF_FFFE, 32'd1,         "modw_7_m2"},
      '{DIV_WU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  "divwu_max_1"}
   };

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op = 2'b00;
      a = 32'h0;
      b = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", {31'h0, busy}, 32'h0);
      check("reset done", {31'h0, done}, 32'h0);
      check("reset y", y, 32'h0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, 1'b1, vecs[i].name);
         drain(vecs[i].name);
      end

      // Flush mid-operation: no done, y retained, busy drops.
      @(negedge clk);
      issue(DIV_WU, 32'd1000, 32'd3, 32'h0, 1'b0, "flush_op");
      check("flush busy_running", {31'h0, busy}, 32'h1);
      repeat (8) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush busy_after", {31'h0, busy}, 32'h0);
      repeat (40) @(posedge clk);
      check("flush y_kept", y, last_y);

      // flush and start together: request dropped.
      @(negedge clk);
      flush = 1'b1;
      issue(DIV_WU, 32'd9, 32'd3, 32'h0, 1'b0, "flush_start");
      flush = 1'b0;
      check("flush_start busy", {31'h0, busy}, 32'h0);

      // start pulsed mid-operation is ignored.
      @(negedge clk);
      issue(DIV_WU, 32'd50, 32'd5, 32'd10, 1'b1, "ignore_start");
      repeat (5) @(posedge clk);
      @(negedge clk);
      issue(DIV_WU, 32'd9, 32'd3, 32'h0, 1'b0, "ignored");
      drain("ignore_start");
      repeat (40) @(posedge clk);
      check("ignore_start idle", {31'h0, busy}, 32'h0);

      // Back-to-back: start sampled at the edge ending the done cycle.
      @(negedge clk);
      issue(MOD_WU, 32'd1234, 32'd100, 32'd34, 1'b1, "b2b_first");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 50);
      issue(DIV_W, 32'hFFFF_FFF6, 32'd3, 32'hFFFF_FFFD, 1'b1, "b2b_second");
      drain("b2b");

      // Reset mid-CALC, then a fresh operation.
      @(negedge clk);
      issue(DIV_WU, 32'd77, 32'd7, 32'h0, 1'b0, "rst_op");
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst busy", {31'h0, busy}, 32'h0);
      check("midrst done", {31'h0, done}, 32'h0);
      check("midrst y", y, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(DIV_WU, 32'd15, 32'd4, 32'd3, 1'b1, "after_rst_15_4");
      drain("after_rst");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
